store_checker: RTL and testbench
================================

Name: store_checker

Overview:
- Self-checking responder on the pipelined core's data-memory write port (MemWriteM/DataAdr/WriteData); sits beside dmem in top-level test harnesses.
- Classifies every store as pass, allowed or illegal and drives sticky done/pass/fail status.
- Logs accepted stores into a FIFO drained over a valid/ready port.
- Runs a watchdog so a hung program terminates with a timeout code instead of running forever.

Parameters:
- PASS_ADDR, 32'd100: store address that signals success.
- PASS_DATA, 32'd7: data required at PASS_ADDR for success.
- ALLOW_ADDR, 32'd96: store address tolerated without a verdict.
- DEPTH, 8: log FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 1000: run cycles allowed before timeout; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- MemWriteM  in  1  store strobe from the core, sampled on rising clk.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- done  out  1  verdict reached (sticky).
- pass  out  1  verdict is success (sticky).
- fail_code  out  2  00 none, 01 illegal address, 10 timeout.
- store_count  out  16  stores accepted in RUN; saturates at 16'hFFFF.
- log_valid  out  1  FIFO head valid.
- log_ready  in  1  consumer accepts the head.
- log_addr  out  32  head store address.
- log_data  out  32  head store data.
- log_overflow  out  1  sticky; a store was dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - state=RUN, done=0, pass=0, fail_code=00, store_count=0, cycle counter=0.
  - FIFO empty, log_valid=0, log_addr=0, log_data=0, log_overflow=0.
  - Reset asserted mid-run aborts everything, including a pending FIFO entry; nothing survives.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and hold until reset.
- RUN, per rising edge with MemWriteM=1, checked in this priority:
  - DataAdr==PASS_ADDR and WriteData==PASS_DATA: next state PASS.
  - DataAdr!=ALLOW_ADDR: next state FAIL, fail_code=01. This includes PASS_ADDR with wrong data.
  - Otherwise: stay in RUN.
- Every store sampled in RUN, including the one that ends the run, is logged and increments store_count.
- Stores arriving in a terminal state are ignored: not logged, not counted.
- Watchdog:
  - Cycle counter increments every cycle in RUN.
  - When it equals TIMEOUT_CYCLES-1 and no store causes a transition that cycle, next state is TIMEOUT with fail_code=10.
  - A store on the expiry cycle is evaluated first and its verdict wins.
- Outputs are registered:
  - done/pass/fail_code update on the edge after the deciding store is sampled (1-cycle latency).
  - pass=1 only in PASS; done=1 in any terminal state.
- FIFO:
  - Push on a logged store. Pop when log_valid&&log_ready.
  - log_addr/log_data are registered head outputs, stable while log_valid=1 and log_ready=0.
  - Empty plus push: no bypass; log_valid rises the next cycle.
  - Full, push, no pop: store dropped, log_overflow set (sticky); store_count still increments.
  - Full, push and pop on the same cycle: both happen, no overflow.
  - Empty plus log_ready: no effect.
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally.
- All comparisons are 32-bit equality.

Decomposition:
- Package store_checker_pkg holds:
  - the state enum (RUN, PASS, FAIL, TIMEOUT);
  - fail code constants FAIL_NONE, FAIL_ADDR, FAIL_TIMEOUT;
  - the log entry width (64).
- One sub-module, sync_fifo: parameterised width/depth, valid/ready read side, push/full write side. store_checker holds the FSM, watchdog and counters.

Test Plan:
- Reset held 22 ns, then stores (96,0), (96,3), (100,7) -> pass=1, done=1, fail_code=00 one cycle after the third store; store_count=3; FIFO drains (96,0), (96,3), (100,7) in order.
- Store (100,6) -> done=1, pass=0, fail_code=01. A later store (100,7) is ignored and store_count stays 1.
- Store (104,7) -> fail_code=01. Store (96,x) then idle with TIMEOUT_CYCLES=20 -> fail_code=10 after exactly 20 RUN cycles.
- Store (100,7) on the expiry cycle -> pass=1, fail_code=00.
- DEPTH=8, log_ready=0, nine stores to 96 -> entries 1-8 retained, log_overflow=1, store_count=9. Then push and pop together on a full FIFO -> no loss, no new overflow.
- Reset asserted mid-drain with 3 entries held -> log_valid=0, store_count=0, state RUN immediately; a subsequent (100,7) passes.

Source files
------------

// File: rtl/store_checker_pkg.sv
// store_checker_pkg: shared types and constants for the store checker.
//   state_t      - verdict FSM states (RUN is the only non-terminal state)
//   FAIL_*       - fail_code encodings
//   LOG_W        - width of one log entry: {address, data}
package store_checker_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_ADDR    = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;

  localparam int unsigned LOG_W = 64;

endpackage

// File: rtl/store_checker_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head (no write-to-read bypass).
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write side; o_full reports no free slot
//   o_valid, i_ready  read side handshake; pop on o_valid && i_ready
//   o_data            registered head entry, stable while not popped
// A push while full is accepted only if a pop happens on the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = r_valid && i_ready;
  assign w_wr_en = i_push && (!w_full || w_pop);

  assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_wr_en);
  assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);

  // The head register is loaded with the entry the read pointer will address
  // after this edge. That slot equals the one being written only when the
  // FIFO is (or becomes) empty, in which case the incoming data is the head.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    if (w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0])) begin
      w_head_nxt = i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i[AW-1:0]] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
    end
  end

  assign o_full  = w_full;
  assign o_valid = r_valid;
  assign o_data  = r_head;

endmodule

// File: rtl/store_checker.sv
// store_checker: watches the core's data-memory write port and produces a
// sticky verdict, logs accepted stores, and times out a hung program.
//   clk, reset                 clock, asynchronous active-high reset
//   MemWriteM/DataAdr/WriteData store port from the core
//   done/pass/fail_code        registered sticky verdict
//   store_count                stores accepted while running (saturating)
//   log_valid/log_ready        log FIFO read handshake
//   log_addr/log_data          registered FIFO head
//   log_overflow               sticky: a store was dropped on a full FIFO
module store_checker
  import store_checker_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADDR     = 32'd96,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  w_fail_nxt;
  logic [31:0] r_cycles;
  logic [15:0] r_store_count;
  logic        r_done;
  logic        r_pass;
  logic [1:0]  r_fail_code;
  logic        r_overflow;

  logic             w_store;
  logic             w_fifo_full;
  logic             w_fifo_valid;
  logic             w_drop;
  logic [LOG_W-1:0] w_head;

  assign w_store = MemWriteM && (r_state == RUN);
  assign w_drop  = w_store && w_fifo_full && !(w_fifo_valid && log_ready);

  // Store verdicts take priority over the watchdog on the expiry cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_code;
    if (r_state == RUN) begin
      if (MemWriteM && (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA)) begin
        w_state_nxt = PASS;
      end else if (MemWriteM && (DataAdr != ALLOW_ADDR)) begin
        w_state_nxt = FAIL;
        w_fail_nxt  = FAIL_ADDR;
      end else if (r_cycles == LAST_CYCLE) begin
        w_state_nxt = TIMEOUT;
        w_fail_nxt  = FAIL_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_cycles      <= '0;
      r_store_count <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_code   <= FAIL_NONE;
      r_overflow    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_code <= w_fail_nxt;
      r_done      <= (w_state_nxt != RUN);
      r_pass      <= (w_state_nxt == PASS);
      if (r_state == RUN) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (w_store && (r_store_count != '1)) begin
        r_store_count <= r_store_count + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (DEPTH)
  ) u_log_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_store),
    .i_data  ({DataAdr, WriteData}),
    .o_full  (w_fifo_full),
    .o_valid (w_fifo_valid),
    .i_ready (log_ready),
    .o_data  (w_head)
  );

  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_code    = r_fail_code;
  assign store_count  = r_store_count;
  assign log_valid    = w_fifo_valid;
  assign log_addr     = w_head[LOG_W-1:32];
  assign log_data     = w_head[31:0];
  assign log_overflow = r_overflow;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: directed-vector bench for store_checker with hand-computed
// expectations. DUT built with DEPTH=8 and TIMEOUT_CYCLES=20.
module tb_store_checker;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [15:0] store_count;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  int unsigned n_tests;
  int unsigned n_fail;

  store_checker #(
    .PASS_ADDR      (32'd100),
    .PASS_DATA      (32'd7),
    .ALLOW_ADDR     (32'd96),
    .DEPTH          (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .done         (done),
    .pass         (pass),
    .fail_code    (fail_code),
    .store_count  (store_count),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWriteM = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWriteM = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  // Leaves time 1 ns after an edge with reset released, so the next tick is
  // the first RUN edge.
  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #10 reset = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_valid"}, {31'd0, log_valid}, 32'd1);
    check({tag, "_addr"}, log_addr, a);
    check({tag, "_data"}, log_data, d);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    MemWriteM = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    log_ready = 1'b0;
    #22 reset = 1'b0;

    // Reset state
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fail", {30'd0, fail_code}, 32'd0);
    check("rst_count", {16'd0, store_count}, 32'd0);
    check("rst_valid", {31'd0, log_valid}, 32'd0);
    check("rst_addr", log_addr, 32'd0);
    check("rst_data", log_data, 32'd0);
    check("rst_ovf", {31'd0, log_overflow}, 32'd0);

    // Allowed, allowed, pass; then drain the log in order
    store(32'd96, 32'd0);
    store(32'd96, 32'd3);
    check("s1_done_early", {31'd0, done}, 32'd0);
    store(32'd100, 32'd7);
    check("s1_done", {31'd0, done}, 32'd1);
    check("s1_pass", {31'd0, pass}, 32'd1);
    check("s1_fail", {30'd0, fail_code}, 32'd0);
    check("s1_count", {16'd0, store_count}, 32'd3);
    log_ready = 1'b1;
    expect_head("s1_h0", 32'd96, 32'd0);
    tick();
    expect_head("s1_h1", 32'd96, 32'd3);
    tick();
    expect_head("s1_h2", 32'd100, 32'd7);
    tick();
    check("s1_empty", {31'd0, log_valid}, 32'd0);
    log_ready = 1'b0;

    // Pass address with wrong data is illegal; later stores ignored
    apply_reset();
    store(32'd100, 32'd6);
    check("s2_done", {31'd0, done}, 32'd1);
    check("s2_pass", {31'd0, pass}, 32'd0);
    check("s2_fail", {30'd0, fail_code}, 32'd1);
    store(32'd100, 32'd7);
    check("s2_pass_after", {31'd0, pass}, 32'd0);
    check("s2_fail_after", {30'd0, fail_code}, 32'd1);
    check("s2_count", {16'd0, store_count}, 32'd1);
    expect_head("s2_h0", 32'd100, 32'd6);

    // Illegal address
    apply_reset();
    store(32'd104, 32'd7);
    check("s3_fail", {30'd0, fail_code}, 32'd1);
    check("s3_done", {31'd0, done}, 32'd1);

    // Watchdog: one allowed store then idle; expires on the 20th RUN edge
    apply_reset();
    store(32'd96, 32'd5);
    repeat (18) tick();
    check("s4_done_19", {31'd0, done}, 32'd0);
    tick();
    check("s4_done_20", {31'd0, done}, 32'd1);
    check("s4_fail", {30'd0, fail_code}, 32'd2);
    check("s4_pass", {31'd0, pass}, 32'd0);
    check("s4_count", {16'd0, store_count}, 32'd1);

    // Passing store on the expiry cycle wins over the timeout
    apply_reset();
    repeat (19) tick();
    check("s5_done_19", {31'd0, done}, 32'd0);
    store(32'd100, 32'd7);
    check("s5_done", {31'd0, done}, 32'd1);
    check("s5_pass", {31'd0, pass}, 32'd1);
    check("s5_fail", {30'd0, fail_code}, 32'd0);

    // Overflow: eight fit, ninth dropped; then push+pop on a full FIFO
    apply_reset();
    for (int i = 1; i <= 8; i++) store(32'd96, 32'(i));
    check("s6_ovf_full", {31'd0, log_overflow}, 32'd0);
    store(32'd96, 32'd9);
    check("s6_ovf", {31'd0, log_overflow}, 32'd1);
    check("s6_count9", {16'd0, store_count}, 32'd9);
    expect_head("s6_h", 32'd96, 32'd1);
    log_ready = 1'b1;
    store(32'd96, 32'd10);
    log_ready = 1'b0;
    check("s6_count10", {16'd0, store_count}, 32'd10);
    log_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      expect_head($sformatf("s6_d%0d", i), 32'd96, 32'(i));
      tick();
    end
    expect_head("s6_d10", 32'd96, 32'd10);
    tick();
    check("s6_empty", {31'd0, log_valid}, 32'd0);
    log_ready = 1'b0;

    // Push+pop on a full FIFO from a clean state: no overflow
    apply_reset();
    for (int i = 1; i <= 8; i++) store(32'd96, 32'(16 + i));
    log_ready = 1'b1;
    store(32'd96, 32'd25);
    log_ready = 1'b0;
    check("s7_ovf", {31'd0, log_overflow}, 32'd0);
    expect_head("s7_h", 32'd96, 32'd18);

    // Reset mid-drain clears everything immediately
    apply_reset();
    for (int i = 0; i < 4; i++) store(32'd96, 32'(i));
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    expect_head("s8_pre", 32'd96, 32'd1);
    reset = 1'b1;
    #1;
    check("s8_valid", {31'd0, log_valid}, 32'd0);
    check("s8_count", {16'd0, store_count}, 32'd0);
    check("s8_addr", log_addr, 32'd0);
    check("s8_done", {31'd0, done}, 32'd0);
    #8 reset = 1'b0;
    store(32'd100, 32'd7);
    check("s8_pass", {31'd0, pass}, 32'd1);
    check("s8_count_after", {16'd0, store_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
